// File: rtl/dbg_wb_bridge.sv
// dbg_wb_bridge: byte-stream debug command bridge acting as a Wishbone master.
// 'W'+adr+data and 'R'+adr frames each run one single-beat classic bus cycle.
module dbg_wb_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_TMO = 8'h54;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP
    } state_t;

    state_t      state;
    // Frame byte index while receiving, bytes still to send while responding.
    logic [1:0]  cnt;
    logic [31:0] tmo;
    logic [23:0] rd_rest;
    logic        rx_fire;
    logic        tx_fire;
    logic        tmo_hit;

    assign rx_fire  = rx_valid && rx_ready;
    assign tx_fire  = tx_valid && tx_ready;
    assign tmo_hit  = (TIMEOUT != 0) && ((tmo + 32'd1) == TIMEOUT);
    assign wb_sel_o = 4'hF;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            tmo      <= 32'd0;
            rd_rest  <= 24'd0;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= 32'd0;
            wb_dat_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        cnt <= 2'd0;
                        if (rx_data == OP_WR || rx_data == OP_RD) begin
                            wb_we_o <= (rx_data == OP_WR);
                            state   <= ADDR;
                        end else begin
                            rx_ready <= 1'b0;
                            tx_valid <= 1'b1;
                            tx_data  <= RSP_BAD;
                            state    <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        wb_adr_o <= {wb_adr_o[23:0], rx_data};
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            if (wb_we_o) begin
                                state <= DATA;
                            end else begin
                                rx_ready <= 1'b0;
                                wb_cyc_o <= 1'b1;
                                wb_stb_o <= 1'b1;
                                tmo      <= 32'd0;
                                state    <= BUS;
                            end
                        end
                    end
                end
                DATA: begin
                    if (rx_fire) begin
                        wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            rx_ready <= 1'b0;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            tmo      <= 32'd0;
                            state    <= BUS;
                        end
                    end
                end
                BUS: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                        if (wb_we_o) begin
                            tx_data <= RSP_OK;
                            cnt     <= 2'd0;
                        end else begin
                            tx_data <= wb_dat_i[31:24];
                            rd_rest <= wb_dat_i[23:0];
                            cnt     <= 2'd3;
                        end
                    end else if (tmo_hit) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_TMO;
                        cnt      <= 2'd0;
                        state    <= RESP;
                    end else begin
                        tmo <= tmo + 32'd1;
                    end
                end
                RESP: begin
                    if (tx_fire) begin
                        if (cnt == 2'd0) begin
                            tx_valid <= 1'b0;
                            rx_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            cnt     <= cnt - 2'd1;
                            tx_data <= rd_rest[23:16];
                            rd_rest <= {rd_rest[15:0], 8'h00};
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dbg_wb_bridge.md
# dbg_wb_bridge

Byte-stream debug bridge acting as the Wishbone master in front of the debug register slave (LED register at address 0). Takes framed read/write commands from an upstream byte source (UART receiver or host FIFO), runs one single-beat classic Wishbone cycle per command, and returns a status or read-data byte stream to a downstream byte sink. A bus timeout keeps the bridge from hanging on an unmapped or dead address.

## Interface
- `TIMEOUT`, default 255: cycles to wait for `wb_ack_i` before aborting the cycle. A value of 0 disables the timeout.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, synchronous and active-low (0 = reset). Sampled on the `wb_clk_i` rising edge.
- `rx_data` in 8: command byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: bridge accepts a byte when `rx_valid && rx_ready`.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink takes a byte when `tx_valid && tx_ready`.
- `wb_adr_o` out 32, `wb_dat_o` out 32, `wb_we_o` out 1, `wb_sel_o` out 4, `wb_stb_o` out 1, `wb_cyc_o` out 1: Wishbone master outputs.
- `wb_dat_i` in 32, `wb_ack_i` in 1: Wishbone master inputs.

## Operation
- Write frame: 0x57 ('W'), 4 address bytes MSB first, 4 data bytes MSB first. Response: 0x4B ('K').
- Read frame: 0x52 ('R'), 4 address bytes MSB first. Response: 4 read-data bytes, MSB first.
- Any other opcode byte is consumed, no bus cycle is run, and the response is 0x3F ('?').
- Timeout on a write or a read: the response is the single byte 0x54 ('T'). A timed-out read sends no data bytes.
- `wb_sel_o` is always 4'hF. `wb_adr_o`, `wb_dat_o` and `wb_we_o` are registered and stable for the whole cycle.
- State machine:
  - IDLE: `rx_ready`=1. On an accepted opcode: 'W' or 'R' → ADDR with byte count 0. Other opcode → RESP with 1 byte = 0x3F.
  - ADDR: `rx_ready`=1. Shift bytes into the address register. After the 4th byte: write → DATA, read → BUS.
  - DATA: `rx_ready`=1. Shift 4 bytes into the write-data register, then → BUS.
  - BUS: `rx_ready`=0. `wb_cyc_o`=`wb_stb_o`=1. Exit on `wb_ack_i` or timeout.
    - On ack: latch `wb_dat_i` (reads), drop cyc/stb, → RESP.
    - On timeout: drop cyc/stb, → RESP with 0x54.
  - RESP: `rx_ready`=0, `tx_valid`=1. Advance one byte per `tx_valid && tx_ready`. After the last byte → IDLE.
- Read data is shifted out from bits [31:24] down to [7:0].

## Timing
- Reset values:
  - `rx_ready`=0, `tx_valid`=0, `tx_data`=0.
  - `wb_cyc_o`=0, `wb_stb_o`=0, `wb_we_o`=0, `wb_adr_o`=0, `wb_dat_o`=0.
  - `wb_sel_o`=4'hF.
  - State IDLE, all counters 0.
  - `rx_ready` rises the first cycle after reset is released.
- Reset mid-operation: takes effect at the next edge. It aborts any frame, bus cycle or response in progress. `wb_cyc_o` and `wb_stb_o` are 0 in the cycle after reset is sampled, and no partial response byte is sent.
- Bus cycle start: cyc/stb assert on the edge that accepts the final frame byte. That byte is the 5th for a read and the 9th for a write.
- Bus cycle end: the slave registers its ack, so ack arrives at the earliest one cycle after stb. Ack is sampled at edge N; cyc/stb are 0 after edge N; `tx_valid` is 1 after edge N.
- Timeout counter:
  - Cleared when BUS is entered and increments every BUS cycle.
  - Timeout fires when the count reaches `TIMEOUT` with no ack, so cyc stays high for exactly `TIMEOUT` cycles.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP backpressure: `tx_data` and `tx_valid` hold unchanged while `tx_ready`=0.
- Back-to-back frames: after the last response byte is taken, `rx_ready` is 1 on the next cycle. Bytes offered earlier stall because `rx_ready`=0.
- No combinational path exists from any input to any output. All outputs are registered.

## Test plan
- Write: send 57 00 00 00 00 00 00 00 00; slave acks one cycle after stb. Expect one cycle with adr=0, dat=0, we=1, sel=F, and cyc high for 2 cycles. Expect `tx` to emit 4B.
- Read: send 52 00 00 00 00; slave returns 0x00000001. Expect we=0 and `tx` to emit 00 00 00 01 in order.
- Timeout: `TIMEOUT`=16, read with `wb_ack_i` held 0. Expect cyc high for exactly 16 cycles, then `tx` emits 54 only. The next frame must work normally.
- Bad opcode and backpressure: send 41. Expect 3F with no bus cycle. Hold `tx_ready`=0 for 10 cycles during a read response; `tx_data` must stay stable and no byte may be lost or duplicated.
- Reset mid-operation: assert reset low during BUS, then during RESP after 2 of 4 bytes. Expect cyc/stb/`tx_valid` = 0 the next cycle and all reset values present. A fresh write after release completes with 4B.
- Randomized stream: a random mix of valid and invalid frames with random ack delays below `TIMEOUT` and random `tx_ready` gaps. A scoreboard must match every response against a reference memory model.
